// File: rtl/poly_pkg.sv
// poly_pkg
//   Shared definitions for the polynomial datapath:
//   - mode encoding carried with every butterfly beat
//   - default coefficient width and modulus
//   - Barrett reduction constants derived from the modulus
//   - single-correction modular add / subtract helpers
//   The helpers work on 32-bit operands so any coefficient width up to 31 bits
//   can use them by zero-extending on the way in and truncating on the way out.
package poly_pkg;

    localparam int unsigned POLY_WID    = 12;
    localparam int unsigned POLY_Q      = 3329;
    localparam int unsigned POLY_SELWID = 2;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_BYP  = 2'd2,
        MODE_PWM  = 2'd3
    } poly_mode_e;

    // mu = floor(2**(2*wid) / q); with k = 2*wid the quotient estimate for any
    // product of two reduced operands is at most one short of the true quotient.
    function automatic longint unsigned barrett_mu(input int unsigned q, input int unsigned wid);
        return (64'd1 << (2 * wid)) / 64'(q);
    endfunction

    localparam int unsigned     BARRETT_K  = 2 * POLY_WID;
    localparam longint unsigned BARRETT_MU = barrett_mu(POLY_Q, POLY_WID);

    // (x + y) mod q for x, y < q
    function automatic logic [31:0] poly_mod_add(input logic [31:0] x,
                                                 input logic [31:0] y,
                                                 input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[31:0];
    endfunction

    // (x - y) mod q for x, y < q
    function automatic logic [31:0] poly_mod_diff(input logic [31:0] x,
                                                  input logic [31:0] y,
                                                  input logic [31:0] q);
        logic [31:0] s;
        if (x >= y) begin
            s = x - y;
        end else begin
            s = x + q - y;
        end
        return s;
    endfunction

endpackage

// File: rtl/mod_mul_red.sv
// mod_mul_red
//   Registered modular multiplier: r = (x * y) mod Q, two cycles of latency.
//   Cycle 1 registers the full 2*WID-bit product, cycle 2 registers the
//   Barrett-reduced result. Both registers advance only while en is high so
//   the multiplier stalls in lock-step with the surrounding pipeline.
// Ports
//   clk  - clock
//   rst  - synchronous reset, active low
//   en   - pipeline advance
//   x, y - operands, each < Q
//   r    - reduced product, always in [0, Q)
module mod_mul_red
    import poly_pkg::*;
#(
    parameter int unsigned WID = POLY_WID,
    parameter int unsigned Q   = POLY_Q
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [WID-1:0] x,
    input  logic [WID-1:0] y,
    output logic [WID-1:0] r
);

    localparam int unsigned PW = 2 * WID;
    localparam logic [PW:0] MU = (PW+1)'(barrett_mu(Q, WID));

    logic [PW-1:0]  p_d, p_q;
    logic [WID-1:0] r_d, r_q;
    logic [2*PW:0]  bprod;
    logic [PW:0]    qhat;
    logic [PW:0]    rem;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = PW'(x) * PW'(y);
        end

        // qhat underestimates floor(p/Q) by at most one, so the remainder
        // lands in [0, 2Q) and a single subtract brings it into range.
        // PW+1 bits hold that remainder exactly, so the wrap-around arithmetic
        // below is safe.
        bprod = (2*PW+1)'(p_q) * (2*PW+1)'(MU);
        qhat  = (PW+1)'(bprod >> PW);
        rem   = (PW+1)'(p_q) - qhat * (PW+1)'(Q);
        if (rem >= (PW+1)'(Q)) begin
            rem = rem - (PW+1)'(Q);
        end

        r_d = r_q;
        if (en) begin
            r_d = WID'(rem);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q <= '0;
            r_q <= '0;
        end else begin
            p_q <= p_d;
            r_q <= r_d;
        end
    end

    assign r = r_q;

endmodule

// File: rtl/bfly_pipe_unit.sv
// bfly_pipe_unit
//   Multi-lane modular butterfly with a fixed four-stage in-order pipeline.
//   Each beat carries its own mode (NTT, INTT, bypass, pointwise multiply) and
//   all LANES lanes share one valid/ready handshake. The whole pipeline
//   advances together when the output register is empty or being drained, so
//   a downstream stall freezes every stage without losing beats.
//   Stage 1: input register (a, b, w, mode, and (a-b) mod Q for INTT)
//   Stage 2: products            (inside mod_mul_red)
//   Stage 3: Barrett reduction   (inside mod_mul_red)
//   Stage 4: final add/sub/select into the output register
// Ports
//   clk, rst            - clock, synchronous active-low reset
//   in_valid / in_ready - input handshake; in_ready is the pipeline enable
//   sel                 - beat mode: 0 NTT, 1 INTT, 2 BYPASS, 3 PWMUL
//   a, b, w             - LANES packed coefficients, lane i at [i*WID +: WID]
//   out_valid/out_ready - output handshake
//   c, d                - LANES packed results
//   out_sel             - mode of the beat on c/d
//   inflight            - number of beats currently held (0..4)
module bfly_pipe_unit
    import poly_pkg::*;
#(
    parameter int unsigned WID    = POLY_WID,
    parameter int unsigned Q      = POLY_Q,
    parameter int unsigned LANES  = 2,
    parameter int unsigned SELWID = POLY_SELWID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELWID-1:0]    sel,
    input  logic [LANES*WID-1:0] a,
    input  logic [LANES*WID-1:0] b,
    input  logic [LANES*WID-1:0] w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*WID-1:0] c,
    output logic [LANES*WID-1:0] d,
    output logic [SELWID-1:0]    out_sel,
    output logic [2:0]           inflight
);

    localparam logic [SELWID-1:0] SEL_NTT  = SELWID'(MODE_NTT);
    localparam logic [SELWID-1:0] SEL_INTT = SELWID'(MODE_INTT);
    localparam logic [SELWID-1:0] SEL_PWM  = SELWID'(MODE_PWM);

    localparam int unsigned DW = LANES * WID;

    logic en;
    logic acc;
    logic pop;

    logic          s1_valid_d, s1_valid_q;
    logic [SELWID-1:0] s1_sel_d, s1_sel_q;
    logic [DW-1:0] s1_a_d, s1_a_q;
    logic [DW-1:0] s1_b_d, s1_b_q;
    logic [DW-1:0] s1_w_d, s1_w_q;
    logic [DW-1:0] s1_t_d, s1_t_q;

    logic          s2_valid_d, s2_valid_q;
    logic [SELWID-1:0] s2_sel_d, s2_sel_q;
    logic [DW-1:0] s2_a_d, s2_a_q;
    logic [DW-1:0] s2_b_d, s2_b_q;

    logic          s3_valid_d, s3_valid_q;
    logic [SELWID-1:0] s3_sel_d, s3_sel_q;
    logic [DW-1:0] s3_a_d, s3_a_q;
    logic [DW-1:0] s3_b_d, s3_b_q;

    logic          out_valid_d, out_valid_q;
    logic [SELWID-1:0] out_sel_d, out_sel_q;
    logic [DW-1:0] c_d, c_q;
    logic [DW-1:0] d_d, d_q;
    logic [2:0]    inflight_d, inflight_q;

    logic [DW-1:0] t_in;
    logic [DW-1:0] c_res;
    logic [DW-1:0] d_res;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign acc      = in_valid && en;
    assign pop      = out_valid_q && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WID-1:0] mc_x;
        logic [WID-1:0] md_x;
        logic [WID-1:0] rc;
        logic [WID-1:0] rd;
        logic [WID-1:0] c_l;
        logic [WID-1:0] d_l;

        // INTT difference is formed ahead of the input register so stage 2
        // only has to pick a multiplicand.
        assign t_in[i*WID +: WID] = WID'(poly_mod_diff(32'(a[i*WID +: WID]),
                                                       32'(b[i*WID +: WID]),
                                                       32'(Q)));

        // Multiplier c carries the butterfly product (or a*w for PWMUL);
        // multiplier d is only busy for PWMUL.
        always_comb begin
            mc_x = '0;
            md_x = '0;
            case (s1_sel_q)
                SEL_NTT:  mc_x = s1_b_q[i*WID +: WID];
                SEL_INTT: mc_x = s1_t_q[i*WID +: WID];
                SEL_PWM: begin
                    mc_x = s1_a_q[i*WID +: WID];
                    md_x = s1_b_q[i*WID +: WID];
                end
                default: ;
            endcase
        end

        mod_mul_red #(
            .WID (WID),
            .Q   (Q)
        ) u_mul_c (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .x   (mc_x),
            .y   (s1_w_q[i*WID +: WID]),
            .r   (rc)
        );

        mod_mul_red #(
            .WID (WID),
            .Q   (Q)
        ) u_mul_d (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .x   (md_x),
            .y   (s1_w_q[i*WID +: WID]),
            .r   (rd)
        );

        always_comb begin
            c_l = s3_a_q[i*WID +: WID];
            d_l = s3_b_q[i*WID +: WID];
            case (s3_sel_q)
                SEL_NTT: begin
                    c_l = WID'(poly_mod_add(32'(s3_a_q[i*WID +: WID]), 32'(rc), 32'(Q)));
                    d_l = WID'(poly_mod_diff(32'(s3_a_q[i*WID +: WID]), 32'(rc), 32'(Q)));
                end
                SEL_INTT: begin
                    c_l = WID'(poly_mod_add(32'(s3_a_q[i*WID +: WID]),
                                            32'(s3_b_q[i*WID +: WID]), 32'(Q)));
                    d_l = rc;
                end
                SEL_PWM: begin
                    c_l = rc;
                    d_l = rd;
                end
                default: ;
            endcase
        end

        assign c_res[i*WID +: WID] = c_l;
        assign d_res[i*WID +: WID] = d_l;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sel_d    = s1_sel_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_w_d      = s1_w_q;
        s1_t_d      = s1_t_q;
        s2_valid_d  = s2_valid_q;
        s2_sel_d    = s2_sel_q;
        s2_a_d      = s2_a_q;
        s2_b_d      = s2_b_q;
        s3_valid_d  = s3_valid_q;
        s3_sel_d    = s3_sel_q;
        s3_a_d      = s3_a_q;
        s3_b_d      = s3_b_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        c_d         = c_q;
        d_d         = d_q;

        if (en) begin
            s1_valid_d = acc;
            if (acc) begin
                s1_sel_d = sel;
                s1_a_d   = a;
                s1_b_d   = b;
                s1_w_d   = w;
                s1_t_d   = t_in;
            end

            s2_valid_d = s1_valid_q;
            s2_sel_d   = s1_sel_q;
            s2_a_d     = s1_a_q;
            s2_b_d     = s1_b_q;

            s3_valid_d = s2_valid_q;
            s3_sel_d   = s2_sel_q;
            s3_a_d     = s2_a_q;
            s3_b_d     = s2_b_q;

            // Bubbles leave the last emitted result on c/d.
            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                out_sel_d = s3_sel_q;
                c_d       = c_res;
                d_d       = d_res;
            end
        end

        case ({acc, pop})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sel_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_w_q      <= '0;
            s1_t_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_sel_q    <= '0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_sel_q    <= '0;
            s3_a_q      <= '0;
            s3_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            c_q         <= '0;
            d_q         <= '0;
            inflight_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sel_q    <= s1_sel_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_w_q      <= s1_w_d;
            s1_t_q      <= s1_t_d;
            s2_valid_q  <= s2_valid_d;
            s2_sel_q    <= s2_sel_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s3_valid_q  <= s3_valid_d;
            s3_sel_q    <= s3_sel_d;
            s3_a_q      <= s3_a_d;
            s3_b_q      <= s3_b_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            c_q         <= c_d;
            d_q         <= d_d;
            inflight_q  <= inflight_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign c         = c_q;
    assign d         = d_q;
    assign inflight  = inflight_q;

endmodule

// File: doc/bfly_pipe_unit.md
Name: bfly_pipe_unit

Overview:
- Parametrised, multi-lane modular butterfly with valid/ready flow control.
- Per-beat modes: Cooley-Tukey NTT, Gentleman-Sande INTT, bypass, and a new pointwise-multiply mode.
- Fixed-latency in-order pipeline with stall support, so the polynomial unit's address/memory controller can back-pressure it without losing beats.
- Sits between coefficient RAM read ports and the write-back path; LANES butterflies share one handshake.

Parameters:
- WID, 12, coefficient width in bits.
- Q, 3329, modulus; must satisfy Q < 2**WID.
- LANES, 2, parallel butterflies per beat.
- SELWID, 2, mode field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- sel  in  SELWID  mode for this beat: 0 NTT, 1 INTT, 2 BYPASS, 3 PWMUL.
- a  in  LANES*WID  lane i at [i*WID +: WID]; each lane value < Q.
- b  in  LANES*WID  as a.
- w  in  LANES*WID  twiddle or multiplier per lane; each lane value < Q.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- c  out  LANES*WID  first result per lane.
- d  out  LANES*WID  second result per lane.
- out_sel  out  SELWID  mode tag of the output beat.
- inflight  out  3  number of beats held in the pipeline (0..4).

Behaviour:
- Reset (rst==0 at a clk edge):
  - all pipeline valid bits, out_valid, c, d and out_sel go to 0; inflight goes to 0.
  - In-flight beats are discarded, including mid-operation; nothing is emitted afterwards.
- Advance/stall:
  - Pipeline enable en = !out_valid || out_ready; in_ready = en (combinational).
  - Accept when in_valid && in_ready. When en==0, every stage holds, including data, tags and valids.
- Latency and ordering:
  - Fixed 4 cycles from accept to out_valid when unstalled, identical for all modes (bypass included), so ordering is strictly preserved.
  - Throughput is 1 beat/cycle.
  - Mode and data travel together, so sel may change on every beat.
- Stage 1 (register):
  - Latch a, b, w, sel.
  - For INTT, compute t = (a-b) mod Q combinationally before the register.
- Stage 2: product p = m1*m2 (2*WID bits).
  - NTT: w*b.
  - INTT: w*t.
  - PWMUL lane: w*a for c and w*b for d, which needs two multipliers per lane.
  - BYPASS: no product.
- Stage 3: r = p mod Q via Barrett reduction, exact result in [0,Q).
- Stage 4 (output register):
  - NTT: c = (a+r) mod Q, d = (a-r) mod Q.
  - INTT: c = (a+b) mod Q, d = r.
  - BYPASS: c = a, d = b.
  - PWMUL: c = (a*w) mod Q, d = (b*w) mod Q.
- Modular add/sub: at most one conditional correction (add or subtract Q). Outputs are always < Q for in-range inputs; behaviour for inputs >= Q is unspecified.
- inflight:
  - +1 on accept, -1 on out_valid && out_ready; both in one cycle leaves it unchanged.
  - It never exceeds 4: when the pipeline is full and stalled, in_ready is 0.
- Lanes are fully independent; there is no carry or interaction across lane boundaries.

Decomposition:
- Shared package (poly_pkg):
  - mode constants MODE_NTT=0, MODE_INTT=1, MODE_BYP=2, MODE_PWM=3;
  - default Q, WID;
  - Barrett constants (shift k = 2*WID, mu = floor(2**k / Q)) computed from Q.
- Sub-module: mod_mul_red, a registered WID x WID multiply plus Barrett reduction covering stages 2-3. It has an enable input and a latency of 2, and is instantiated twice per lane.
- Modular add and sub reuse poly_mod_add and poly_mod_diff.

Test Plan:
- NTT, Q=3329, lane0 a=5, b=7, w=17, out_ready=1 -> 4 cycles later c=124, d=3215, out_sel=0.
- Wrap boundary, NTT a=b=w=3328 -> c=0, d=3327. INTT on a=5, b=7, w=17 -> c=12, d=3295.
- Back-to-back modes NTT, INTT, BYPASS(a=9, b=10), PWMUL(a=5, b=7, w=17) on consecutive cycles -> outputs on consecutive cycles in order: (124,3215), (12,3295), (9,10), (85,119), with out_sel tags 0,1,2,3.
- Back-pressure:
  - Hold out_ready=0 while streaming 6 beats -> in_ready drops once inflight=4; exactly 4 beats are accepted; c/d stay stable while stalled.
  - Release out_ready -> all beats emerge in order with none lost or duplicated.
- Reset mid-operation:
  - Drive rst=0 for 1 cycle with 3 beats in flight -> next cycle out_valid=0, c=d=0, inflight=0, in_ready=1; no stale beat ever appears.
  - Check that an async-style pulse between edges has no effect.
- Lane independence, LANES=2: lane1 gets a=3328, b=1, w=1 NTT while lane0 gets a=0, b=0 -> lane1 (0,3327), lane0 (0,0).
